// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem peripheral bus controller: FSM encoding,
// page map, status register layout and the default timeout error word.
package iomem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   localparam logic [7:0] PAGE_GPIO   = 8'h03;
   localparam logic [7:0] PAGE_AUDIO  = 8'h04;
   localparam logic [7:0] PAGE_VIDEO  = 8'h05;
   localparam logic [7:0] PAGE_I2C    = 8'h07;
   localparam logic [7:0] PAGE_STATUS = 8'h0F;

   localparam int STAT_BUS_ERR_BIT = 0;
   localparam int STAT_PAGE_LSB    = 8;
   localparam int STAT_COUNT_LSB   = 16;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                               input logic [7:0]  page,
                                               input logic        berr);
      logic [31:0] w;
      w = '0;
      w[STAT_COUNT_LSB +: 16] = cnt;
      w[STAT_PAGE_LSB +: 8]   = page;
      w[STAT_BUS_ERR_BIT]     = berr;
      return w;
   endfunction

endpackage

// File: rtl/iomem_ctrl_if.sv
// CPU-side iomem request/response bundle; the controller is the slave.
interface iomem_if;
   logic        iomem_valid;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic        iomem_ready;
   logic [31:0] iomem_rdata;

   modport master (output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   input  iomem_ready, iomem_rdata);
   modport slave  (input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
                   output iomem_ready, iomem_rdata);
endinterface

// File: rtl/iomem_watchdog.sv
// 16-bit load/decrement counter; expired flags the last cycle before it would hit zero.
module iomem_watchdog (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        dec,
   input  logic [15:0] load_value,
   output logic        expired
);
   logic [15:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && count_reg != 16'd0) begin
         count_reg <= count_reg - 16'd1;
      end
   end

   // A decrement taken while the count is 1 brings it to 0 this very cycle.
   assign expired = (count_reg == 16'd1);
endmodule

// File: rtl/iomem_ctrl.sv
// iomem page decoder and sequencer: strobes one peripheral slot, waits for its
// ack under a watchdog, and returns a single-cycle ready with the read data.
module iomem_ctrl
   import iomem_pkg::*;
#(
   parameter int          NSLOTS      = 8,
   parameter logic [7:0]  BASE_PAGE   = PAGE_GPIO,
   parameter logic [7:0]  STATUS_PAGE = PAGE_STATUS,
   parameter int          TIMEOUT     = 255,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset,
   iomem_if.slave                 iomem,
   output logic [NSLOTS-1:0]      per_sel,
   output logic [NSLOTS-1:0]      per_stb,
   output logic [7:0]             per_addr,
   output logic [3:0]             per_wstrb,
   output logic [31:0]            per_wdata,
   input  logic [NSLOTS*32-1:0]   per_rdata,
   input  logic [NSLOTS-1:0]      per_ack,
   output logic                   bus_err
);
   localparam int SW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

   state_t            state_reg;
   logic              ready_reg;
   logic [31:0]       rdata_reg;
   logic [NSLOTS-1:0] sel_reg;
   logic [NSLOTS-1:0] stb_reg;
   logic [7:0]        addr_reg;
   logic [7:0]        page_reg;
   logic [3:0]        wstrb_reg;
   logic [31:0]       wdata_reg;
   logic [SW-1:0]     slot_reg;
   logic              bus_err_reg;
   logic [15:0]       err_count_reg;
   logic [7:0]        last_err_page_reg;

   logic [7:0]        req_page;
   logic [7:0]        req_offset;
   logic [SW-1:0]     req_slot;
   logic              in_range;
   logic              is_status;
   logic [NSLOTS-1:0] req_onehot;
   logic [31:0]       slot_rdata [NSLOTS];
   logic              ack_hit;
   logic              wd_load;
   logic              wd_dec;
   logic              expired;
   logic              unused_addr_bits;

   assign req_page         = iomem.iomem_addr[31:24];
   assign req_offset       = req_page - BASE_PAGE;
   assign in_range         = {1'b0, req_offset} < 9'(NSLOTS);
   assign req_slot         = req_offset[SW-1:0];
   assign is_status        = (req_page == STATUS_PAGE);
   assign unused_addr_bits = ^iomem.iomem_addr[23:8];

   generate
      for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_slot
         assign req_onehot[gi] = in_range && (req_slot == SW'(gi));
         assign slot_rdata[gi] = per_rdata[32*gi +: 32];
      end
   endgenerate

   // Only the selected slot's ack counts; strays from other slots are masked.
   assign ack_hit = |(per_ack & sel_reg);
   assign wd_load = (state_reg == ST_IDLE) && iomem.iomem_valid && in_range;
   assign wd_dec  = (state_reg == ST_ACCESS) && !ack_hit;

   iomem_watchdog u_watchdog (
      .clk        (clk),
      .reset      (reset),
      .load       (wd_load),
      .dec        (wd_dec),
      .load_value (16'(TIMEOUT)),
      .expired    (expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= ST_IDLE;
         ready_reg         <= 1'b0;
         rdata_reg         <= '0;
         sel_reg           <= '0;
         stb_reg           <= '0;
         addr_reg          <= '0;
         page_reg          <= '0;
         wstrb_reg         <= '0;
         wdata_reg         <= '0;
         slot_reg          <= '0;
         bus_err_reg       <= 1'b0;
         err_count_reg     <= '0;
         last_err_page_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               ready_reg <= 1'b0;
               if (iomem.iomem_valid) begin
                  addr_reg  <= iomem.iomem_addr[7:0];
                  page_reg  <= req_page;
                  wstrb_reg <= iomem.iomem_wstrb;
                  wdata_reg <= iomem.iomem_wdata;
                  if (in_range) begin
                     sel_reg   <= req_onehot;
                     stb_reg   <= req_onehot;
                     slot_reg  <= req_slot;
                     state_reg <= ST_ACCESS;
                  end else begin
                     ready_reg <= 1'b1;
                     state_reg <= ST_RESPOND;
                     if (is_status) begin
                        // Return the pre-clear value even when the write clears it.
                        rdata_reg <= status_word(err_count_reg, last_err_page_reg, bus_err_reg);
                        if (|iomem.iomem_wstrb) begin
                           bus_err_reg       <= 1'b0;
                           err_count_reg     <= '0;
                           last_err_page_reg <= '0;
                        end
                     end else begin
                        rdata_reg <= '0;
                     end
                  end
               end
            end
            ST_ACCESS: begin
               stb_reg <= '0;
               if (ack_hit) begin
                  rdata_reg <= slot_rdata[slot_reg];
                  ready_reg <= 1'b1;
                  sel_reg   <= '0;
                  state_reg <= ST_RESPOND;
               end else if (expired) begin
                  rdata_reg         <= ERR_DATA;
                  bus_err_reg       <= 1'b1;
                  last_err_page_reg <= page_reg;
                  if (err_count_reg != 16'hFFFF) begin
                     err_count_reg <= err_count_reg + 16'd1;
                  end
                  ready_reg <= 1'b1;
                  sel_reg   <= '0;
                  state_reg <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               ready_reg <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign iomem.iomem_ready = ready_reg;
   assign iomem.iomem_rdata = rdata_reg;
   assign per_sel           = sel_reg;
   assign per_stb           = stb_reg;
   assign per_addr          = addr_reg;
   assign per_wstrb         = wstrb_reg;
   assign per_wdata         = wdata_reg;
   assign bus_err           = bus_err_reg;
endmodule

// File: tb/tb_iomem_ctrl.sv
// Directed bench for iomem_ctrl: a vector table of single transactions on two
// instances (TIMEOUT 255 and TIMEOUT 1) plus a hand-written mid-access reset sequence.
module tb_iomem_ctrl;
   localparam int NS = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   iomem_if bus0 ();
   iomem_if bus1 ();

   logic [NS-1:0]    per_sel0, per_stb0, per_ack0, per_sel1, per_stb1, per_ack1;
   logic [7:0]       per_addr0, per_addr1;
   logic [3:0]       per_wstrb0, per_wstrb1;
   logic [31:0]      per_wdata0, per_wdata1;
   logic [NS*32-1:0] per_rdata0, per_rdata1;
   logic             bus_err0, bus_err1;

   iomem_ctrl #(.TIMEOUT(255)) u_dut0 (
      .clk(clk), .reset(reset), .iomem(bus0.slave),
      .per_sel(per_sel0), .per_stb(per_stb0), .per_addr(per_addr0),
      .per_wstrb(per_wstrb0), .per_wdata(per_wdata0), .per_rdata(per_rdata0),
      .per_ack(per_ack0), .bus_err(bus_err0)
   );

   iomem_ctrl #(.TIMEOUT(1)) u_dut1 (
      .clk(clk), .reset(reset), .iomem(bus1.slave),
      .per_sel(per_sel1), .per_stb(per_stb1), .per_addr(per_addr1),
      .per_wstrb(per_wstrb1), .per_wdata(per_wdata1), .per_rdata(per_rdata1),
      .per_ack(per_ack1), .bus_err(bus_err1)
   );

   typedef struct {
      string       name;
      bit          dsel;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      int          ack_slot;
      int          ack_cycle;
      int          ack_len;
      logic [31:0] ack_data;
      int          stray;
      int          exp_cycle;
      logic [31:0] exp_rdata;
      logic        exp_berr;
      logic [7:0]  exp_sel;
      int          exp_stb;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input bit dsel, input logic [31:0] addr,
                               input logic [3:0] wstrb, input logic [31:0] wdata,
                               input int ack_slot, input int ack_cycle, input int ack_len,
                               input logic [31:0] ack_data, input int stray,
                               input int exp_cycle, input logic [31:0] exp_rdata,
                               input logic exp_berr, input logic [7:0] exp_sel,
                               input int exp_stb);
      vec_t v;
      v.name = name; v.dsel = dsel; v.addr = addr; v.wstrb = wstrb; v.wdata = wdata;
      v.ack_slot = ack_slot; v.ack_cycle = ack_cycle; v.ack_len = ack_len;
      v.ack_data = ack_data; v.stray = stray; v.exp_cycle = exp_cycle;
      v.exp_rdata = exp_rdata; v.exp_berr = exp_berr; v.exp_sel = exp_sel;
      v.exp_stb = exp_stb;
      return v;
   endfunction

   task automatic idle_inputs();
      bus0.iomem_valid = 1'b0; bus0.iomem_wstrb = '0; bus0.iomem_addr = '0; bus0.iomem_wdata = '0;
      bus1.iomem_valid = 1'b0; bus1.iomem_wstrb = '0; bus1.iomem_addr = '0; bus1.iomem_wdata = '0;
      per_ack0 = '0; per_ack1 = '0;
   endtask

   // Called just after a rising edge; that cycle is cycle 0 of the transaction.
   task automatic run_txn(input vec_t v);
      logic [NS*32-1:0] rd_bus;
      logic [NS-1:0]    ack;
      logic [7:0]       sel1, pa1;
      logic [3:0]       pw1;
      logic [31:0]      pd1, rd;
      logic             rdy, be;
      int               c, stb_cnt, rc;
      bit               done;
      for (int i = 0; i < NS; i++) rd_bus[32*i +: 32] = 32'hBAD0_0000 | 32'(i);
      if (v.ack_slot >= 0) rd_bus[32*v.ack_slot +: 32] = v.ack_data;
      if (v.dsel) begin
         per_rdata1 = rd_bus; bus1.iomem_valid = 1'b1; bus1.iomem_addr = v.addr;
         bus1.iomem_wstrb = v.wstrb; bus1.iomem_wdata = v.wdata;
      end else begin
         per_rdata0 = rd_bus; bus0.iomem_valid = 1'b1; bus0.iomem_addr = v.addr;
         bus0.iomem_wstrb = v.wstrb; bus0.iomem_wdata = v.wdata;
      end
      c = 0; done = 0; stb_cnt = 0; rc = -1; rd = '0; be = 1'b0;
      sel1 = '0; pa1 = '0; pw1 = '0; pd1 = '0;
      while (!done && c < 400) begin
         ack = '0;
         if (v.ack_slot >= 0 && c >= v.ack_cycle && c < v.ack_cycle + v.ack_len) ack[v.ack_slot] = 1'b1;
         if (v.stray >= 0 && c >= 1 && c <= 3) ack[v.stray] = 1'b1;
         if (v.dsel) per_ack1 = ack; else per_ack0 = ack;
         @(negedge clk);
         if ((v.dsel ? per_stb1 : per_stb0) != '0) stb_cnt++;
         if (c == 1) begin
            sel1 = v.dsel ? per_sel1 : per_sel0;
            pa1  = v.dsel ? per_addr1 : per_addr0;
            pw1  = v.dsel ? per_wstrb1 : per_wstrb0;
            pd1  = v.dsel ? per_wdata1 : per_wdata0;
         end
         rdy = v.dsel ? bus1.iomem_ready : bus0.iomem_ready;
         if (rdy) begin
            done = 1; rc = c;
            rd = v.dsel ? bus1.iomem_rdata : bus0.iomem_rdata;
            be = v.dsel ? bus_err1 : bus_err0;
         end
         @(posedge clk); #1;
         c++;
      end
      idle_inputs();
      if (!done) begin
         checks++; failures++;
         $display("FAIL %s_ready_timeout actual=none required=cycle %0d", v.name, v.exp_cycle);
      end
      chk({v.name, "_ready_cycle"}, 32'(rc), 32'(v.exp_cycle));
      chk({v.name, "_rdata"}, rd, v.exp_rdata);
      chk({v.name, "_bus_err"}, {31'b0, be}, {31'b0, v.exp_berr});
      chk({v.name, "_stb_count"}, 32'(stb_cnt), 32'(v.exp_stb));
      chk({v.name, "_sel"}, {24'b0, sel1}, {24'b0, v.exp_sel});
      if (v.exp_stb != 0) begin
         chk({v.name, "_per_addr"}, {24'b0, pa1}, {24'b0, v.addr[7:0]});
         chk({v.name, "_per_wstrb"}, {28'b0, pw1}, {28'b0, v.wstrb});
         chk({v.name, "_per_wdata"}, pd1, v.wdata);
      end
      // Ready must not repeat in the following cycle.
      @(negedge clk);
      chk({v.name, "_single_ready"}, {31'b0, (v.dsel ? bus1.iomem_ready : bus0.iomem_ready)}, 32'd0);
      @(posedge clk); #1;
      $display("txn %s dut%0d ready_cycle=%0d rdata=%h bus_err=%0b", v.name, v.dsel, rc, rd, be);
   endtask

   vec_t vq[$];
   vec_t after_rst[$];

   initial begin
      idle_inputs();
      per_rdata0 = '0; per_rdata1 = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", {31'b0, bus0.iomem_ready}, 32'd0);
      chk("rst_rdata0", bus0.iomem_rdata, 32'd0);
      chk("rst_sel0", {24'b0, per_sel0}, 32'd0);
      chk("rst_stb0", {24'b0, per_stb0}, 32'd0);
      chk("rst_bus_err0", {31'b0, bus_err0}, 32'd0);
      chk("rst_ready1", {31'b0, bus1.iomem_ready}, 32'd0);
      chk("rst_bus_err1", {31'b0, bus_err1}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      //          name            d  addr          wstrb  wdata         slot cyc len data          stray cyc  rdata         be  sel       stb
      vq.push_back(mk("rd_slot0",    0, 32'h0300_0004, 4'h0, 32'h0,        0,  4, 1, 32'h0000_00A5, -1,   5, 32'h0000_00A5, 0, 8'h01, 1));
      vq.push_back(mk("wr_slot2",    0, 32'h0500_0010, 4'h3, 32'h1234_5678, 2, 1, 1, 32'hC0DE_0002, -1,   2, 32'hC0DE_0002, 0, 8'h04, 1));
      vq.push_back(mk("to_slot1",    0, 32'h0400_0020, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1, 256, 32'hDEAD_BEEF, 1, 8'h02, 1));
      vq.push_back(mk("stat_rd1",    0, 32'h0F00_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0001_0401, 1, 8'h00, 0));
      vq.push_back(mk("unmap_20",    0, 32'h2000_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0,         1, 8'h00, 0));
      vq.push_back(mk("unmap_02",    0, 32'h0200_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0,         1, 8'h00, 0));
      vq.push_back(mk("unmap_0b_wr", 0, 32'h0B00_0000, 4'hF, 32'hFFFF_FFFF,-1,  0, 0, 32'h0,        -1,   1, 32'h0,         1, 8'h00, 0));
      vq.push_back(mk("stat_clr",    0, 32'h0F00_0000, 4'h1, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0001_0401, 0, 8'h00, 0));
      vq.push_back(mk("stat_rd2",    0, 32'h0F00_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0,         0, 8'h00, 0));
      vq.push_back(mk("slot7_hold",  0, 32'h0A00_00FC, 4'h0, 32'h0,        7,  2, 3, 32'h0000_0077, -1,   3, 32'h0000_0077, 0, 8'h80, 1));
      vq.push_back(mk("stray_ack",   0, 32'h0600_0008, 4'h0, 32'h0,        3,  5, 1, 32'h3333_0003,  4,   6, 32'h3333_0003, 0, 8'h08, 1));
      vq.push_back(mk("ack_expire",  1, 32'h0300_0000, 4'h0, 32'h0,        0,  1, 1, 32'h0000_0011, -1,   2, 32'h0000_0011, 0, 8'h01, 1));
      vq.push_back(mk("stat_t1",     1, 32'h0F00_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0,         0, 8'h00, 0));
      vq.push_back(mk("to_t1",       1, 32'h0300_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   2, 32'hDEAD_BEEF, 1, 8'h01, 1));
      vq.push_back(mk("stat_t1_err", 1, 32'h0F00_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1,   1, 32'h0001_0301, 1, 8'h00, 0));
      vq.push_back(mk("to_slot4",    0, 32'h0700_0000, 4'h0, 32'h0,       -1,  0, 0, 32'h0,        -1, 256, 32'hDEAD_BEEF, 1, 8'h10, 1));
      foreach (vq[i]) run_txn(vq[i]);

      // Mid-access reset: a write to slot 0 is left hanging with no ack.
      bus0.iomem_valid = 1'b1; bus0.iomem_addr = 32'h0300_0044;
      bus0.iomem_wstrb = 4'hF; bus0.iomem_wdata = 32'h5555_AAAA;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_sel", {24'b0, per_sel0}, 32'h01);
      #2 reset = 1'b1;
      #1;
      chk("arst_ready", {31'b0, bus0.iomem_ready}, 32'd0);
      chk("arst_rdata", bus0.iomem_rdata, 32'd0);
      chk("arst_sel", {24'b0, per_sel0}, 32'd0);
      chk("arst_stb", {24'b0, per_stb0}, 32'd0);
      chk("arst_addr", {24'b0, per_addr0}, 32'd0);
      chk("arst_wstrb", {28'b0, per_wstrb0}, 32'd0);
      chk("arst_wdata", per_wdata0, 32'd0);
      chk("arst_bus_err", {31'b0, bus_err0}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("arst_no_ready", {31'b0, bus0.iomem_ready}, 32'd0);
      end
      @(posedge clk); #1;
      idle_inputs();
      reset = 1'b0;
      @(posedge clk); #1;
      after_rst.push_back(mk("post_rst_rd", 0, 32'h0300_0004, 4'h0, 32'h0, 0, 2, 1, 32'h0000_005A, -1, 3, 32'h0000_005A, 0, 8'h01, 1));
      after_rst.push_back(mk("post_rst_st", 0, 32'h0F00_0000, 4'h0, 32'h0, -1, 0, 0, 32'h0,        -1, 1, 32'h0,         0, 8'h00, 0));
      foreach (after_rst[i]) run_txn(after_rst[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/iomem_ctrl.md
# iomem_ctrl

Sequencing controller for the picosoc peripheral bus (iomem). It decodes the page in `iomem_addr[31:24]` and issues one-cycle strobes to a bank of peripheral slots (GPIO, audio, video, I2C, ...). It waits for each slot's variable-latency acknowledge and returns a single-cycle `iomem_ready` with the slot's read data. A watchdog terminates stalled accesses with an error word, and a status page records bus errors.

## Interface
- `NSLOTS`, 8: number of peripheral slots; slot i occupies page `BASE_PAGE + i`.
- `BASE_PAGE`, 8'h03: page of slot 0.
- `STATUS_PAGE`, 8'h0F: page of the controller's own status register; must lie outside the slot range.
- `TIMEOUT`, 255: cycles in ACCESS without ack before abort; range 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `iomem_valid`  in  1  CPU request.
- `iomem_wstrb`  in  4  byte write strobes; 0 means read.
- `iomem_addr`  in  32  byte address.
- `iomem_wdata`  in  32  write data.
- `iomem_ready`  out  1  one-cycle completion pulse.
- `iomem_rdata`  out  32  read data, valid while `iomem_ready`=1.
- `per_sel`  out  NSLOTS  one-hot slot select, held for the whole access.
- `per_stb`  out  NSLOTS  one-cycle start pulse, first ACCESS cycle only.
- `per_addr`  out  8  `iomem_addr[7:0]`, registered at accept.
- `per_wstrb`  out  4  registered at accept.
- `per_wdata`  out  32  registered at accept.
- `per_rdata`  in  NSLOTS*32  slot i occupies bits [32i+31:32i].
- `per_ack`  in  NSLOTS  completion from each slot.
- `bus_err`  out  1  sticky flag: a timeout has occurred.

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE with `iomem_valid`=1: latch addr, wstrb and wdata, then decode the page.
  - Slot page: go to ACCESS, set `per_sel`, pulse `per_stb`, load the watchdog with TIMEOUT.
  - STATUS_PAGE: go to RESPOND. A read returns {err_count[15:0], last_err_page[7:0], 7'b0, bus_err}. A write with any `wstrb` bit set clears `bus_err`, `err_count` and `last_err_page`; the returned rdata is the pre-clear value.
  - Unmapped page: go to RESPOND with rdata 32'h0. Writes are discarded.
- ACCESS, each cycle:
  - `per_ack` of the selected slot =1: capture that slot's `per_rdata`, go to RESPOND.
  - Otherwise decrement the watchdog. When it reaches 0: rdata = ERR_DATA, set `bus_err`, set `last_err_page` to the page, increment `err_count` (saturating at 16'hFFFF), go to RESPOND.
  - Ack and watchdog expiry in the same cycle: ack wins and no error is recorded.
  - Acks from unselected slots are ignored.
- RESPOND: `iomem_ready`=1 for exactly one cycle, `per_sel`=0, then go to IDLE. No new request is accepted in the RESPOND cycle.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `iomem_ready`, `iomem_rdata`, `per_sel`, `per_stb`, `per_addr`, `per_wstrb`, `per_wdata`, `bus_err`, `err_count` and `last_err_page` all go to 0.
  - An access in flight is abandoned with no ready pulse. Slots see `per_sel` drop.

## Timing
- `iomem_valid` first high in cycle 0:
  - Slot access: `per_stb` high in cycle 1. An ack sampled in cycle k (k≥1) gives `iomem_ready` in cycle k+1. Minimum latency is 2 cycles.
  - Status or unmapped access: `iomem_ready` in cycle 1.
- Timeout: with no ack, `iomem_ready` is high in cycle TIMEOUT+1, with `bus_err` high in the same cycle.
- All outputs are registered. There are no combinational paths from `per_ack` or `per_rdata` to `iomem_*`.
- Slots may hold `per_ack` high for more than one cycle; only the first cycle counts.
- The CPU drops `iomem_valid` after the ready edge, so IDLE never re-accepts a finished transaction.

## Structure
- Shared package `iomem_pkg`:
  - FSM state encoding.
  - Page constants: GPIO 8'h03, AUDIO 8'h04, VIDEO 8'h05, I2C 8'h07, STATUS 8'h0F.
  - Status field offsets.
  - ERR_DATA default.
- One sub-module, `iomem_watchdog`: a 16-bit load/decrement counter with an `expired` output. All other logic is inline.

## Test plan
- Read slot 0 (addr 32'h0300_0004); the slot acks 3 cycles after `per_stb` with 32'h0000_00A5 -> `per_addr`=8'h04, a single `iomem_ready` in cycle 5, `iomem_rdata`=32'hA5.
- Write 32'h1234_5678 with wstrb 4'b0011 to slot 2 (page 8'h05); the slot acks in the stb cycle -> `per_wdata`=32'h1234_5678, `per_wstrb`=4'b0011, ready in cycle 2, `per_sel`=8'b0000_0100 during ACCESS.
- Read slot 1 with no ack, TIMEOUT=255 -> ready in cycle 256, rdata 32'hDEAD_BEEF, `bus_err`=1. A subsequent status read returns 32'h0001_0400 + 1.
- Read unmapped page 8'h20 -> ready in cycle 1, rdata 0, no `per_stb`. A status write then clears the status register, and the next status read returns 0.
- Ack and expiry in the same cycle with TIMEOUT=1 -> slot data returned, `bus_err` stays 0. A stray ack from an unselected slot is ignored.
- Assert `reset` in the middle of ACCESS -> all outputs 0 asynchronously and no ready pulse. After release, a new read completes normally.
